// File: rtl/hilo_mul_ctrl.sv
// HI/LO sequencer for the shared 32x32 multiplier: owns HI/LO, stalls EX while a
// product is pending, and accumulates MULT/MADD/MSUB results with a same-cycle bypass.
module hilo_mul_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_srca,
  input  logic [31:0] i_srcb,
  input  logic        i_flush,
  output logic        o_busy,
  output logic [31:0] o_hi_out,
  output logic [31:0] o_lo_out,
  output logic        o_mul_in_valid,
  output logic        o_mul_sign,
  output logic [31:0] o_mul_srca,
  output logic [31:0] o_mul_srcb,
  input  logic        i_mul_out_valid,
  input  logic [31:0] i_mul_hi,
  input  logic [31:0] i_mul_lo,
  output logic        o_wd_err
);

  localparam int WCW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic        r_sign;
  logic [63:0] r_prod;
  logic [WCW-1:0] r_wcnt;
  logic        r_wd_err;
  logic        r_mul_in_valid;

  logic        w_start;
  logic        w_mthi;
  logic        w_mtlo;
  logic [63:0] w_acc;

  assign w_start = i_op_valid & ~i_flush & (i_op <= 3'd5);
  assign w_mthi  = i_op_valid & ~i_flush & (i_op == 3'd6);
  assign w_mtlo  = i_op_valid & ~i_flush & (i_op == 3'd7);

  always_comb begin
    w_acc = r_prod;
    case (r_op)
      3'd2, 3'd3: w_acc = {r_hi, r_lo} + r_prod;
      3'd4, 3'd5: w_acc = {r_hi, r_lo} - r_prod;
      default:    w_acc = r_prod;
    endcase
  end

  assign o_busy         = ((r_state == S_IDLE) & w_start) | (r_state == S_WAIT);
  assign o_hi_out       = (r_state == S_ACC) ? w_acc[63:32] : r_hi;
  assign o_lo_out       = (r_state == S_ACC) ? w_acc[31:0]  : r_lo;
  assign o_mul_in_valid = r_mul_in_valid;
  assign o_mul_sign     = r_sign;
  assign o_mul_srca     = r_a;
  assign o_mul_srcb     = r_b;
  assign o_wd_err       = r_wd_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_hi           <= 32'd0;
      r_lo           <= 32'd0;
      r_a            <= 32'd0;
      r_b            <= 32'd0;
      r_op           <= 3'd0;
      r_sign         <= 1'b0;
      r_prod         <= 64'd0;
      r_wcnt         <= '0;
      r_wd_err       <= 1'b0;
      r_mul_in_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a            <= i_srca;
            r_b            <= i_srcb;
            r_op           <= i_op;
            r_sign         <= (i_op == 3'd0) | (i_op == 3'd2) | (i_op == 3'd4);
            r_wcnt         <= '0;
            r_mul_in_valid <= 1'b1;
            r_state        <= S_WAIT;
          end else begin
            if (w_mthi) r_hi <= i_srca;
            if (w_mtlo) r_lo <= i_srca;
          end
        end
        S_WAIT: begin
          // Watchdog only flags; the sequencer keeps waiting for the product.
          if (r_wcnt != WCW'(WAIT_MAX)) r_wcnt <= r_wcnt + 1'b1;
          if (r_wcnt == WCW'(WAIT_MAX - 1)) r_wd_err <= 1'b1;
          if (i_flush) begin
            r_mul_in_valid <= 1'b0;
            r_state        <= S_IDLE;
          end else if (i_mul_out_valid) begin
            r_prod         <= {i_mul_hi, i_mul_lo};
            r_mul_in_valid <= 1'b0;
            r_state        <= S_ACC;
          end
        end
        S_ACC: begin
          // A move in the same cycle is younger than the accumulate, so it wins its half.
          r_hi <= w_mthi ? i_srca : w_acc[63:32];
          r_lo <= w_mtlo ? i_srca : w_acc[31:0];
          if (w_start) begin
            r_a            <= i_srca;
            r_b            <= i_srcb;
            r_op           <= i_op;
            r_sign         <= (i_op == 3'd0) | (i_op == 3'd2) | (i_op == 3'd4);
            r_wcnt         <= '0;
            r_mul_in_valid <= 1'b1;
            r_state        <= S_WAIT;
          end else begin
            r_mul_in_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_mul_in_valid <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Randomized self-checking bench for hilo_mul_ctrl with a behavioural multiplier
// of programmable latency and a 64-bit HI/LO reference model.
module tb_hilo_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        flush;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        mul_in_valid;
  logic        mul_sign;
  logic [31:0] mul_srca;
  logic [31:0] mul_srcb;
  logic        mul_out_valid;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic        wd_err;

  int checks = 0;
  int errors = 0;
  int lat = 3;
  logic withhold = 1'b0;
  int mcnt = 0;
  longint m_sa;
  longint m_sb;
  longint m_prod;
  logic [63:0] m_hl;

  always #5 clk = ~clk;

  hilo_mul_ctrl #(.WAIT_MAX(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid), .i_op(op),
    .i_srca(srca), .i_srcb(srcb), .i_flush(flush), .o_busy(busy),
    .o_hi_out(hi_out), .o_lo_out(lo_out), .o_mul_in_valid(mul_in_valid),
    .o_mul_sign(mul_sign), .o_mul_srca(mul_srca), .o_mul_srcb(mul_srcb),
    .i_mul_out_valid(mul_out_valid), .i_mul_hi(mul_hi), .i_mul_lo(mul_lo),
    .o_wd_err(wd_err)
  );

  // Multiplier model: product valid after lat consecutive in_valid cycles.
  always @(posedge clk) mcnt <= mul_in_valid ? mcnt + 1 : 0;
  assign mul_out_valid = mul_in_valid && !withhold && (mcnt >= lat - 1);

  always_comb begin
    if (mul_sign) begin
      m_sa = $signed(mul_srca);
      m_sb = $signed(mul_srcb);
    end else begin
      m_sa = {32'd0, mul_srca};
      m_sb = {32'd0, mul_srcb};
    end
    m_prod = m_sa * m_sb;
  end
  assign mul_hi = mul_out_valid ? m_prod[63:32] : 32'hDEADBEEF;
  assign mul_lo = mul_out_valid ? m_prod[31:0]  : 32'hBADC0FFE;

  function automatic logic [63:0] ref_next(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hl);
    logic [63:0] ea, eb, p;
    if (o == 3'd0 || o == 3'd2 || o == 3'd4) begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end else begin
      ea = {32'd0, a};
      eb = {32'd0, b};
    end
    p = ea * eb;
    case (o)
      3'd0, 3'd1: return p;
      3'd2, 3'd3: return hl + p;
      3'd4, 3'd5: return hl - p;
      3'd6:       return {a, hl[31:0]};
      default:    return {hl[63:32], a};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    op_valid = 1'b0; op = 3'd0; srca = 32'd0; srcb = 32'd0; flush = 1'b0;
  endtask

  task automatic set_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; srca = a; srcb = b;
  endtask

  // Holds the stalled instruction until the product cycle; returns busy-cycle count.
  task automatic wait_done(output int n);
    logic ov;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (busy) n++;
      ov = mul_out_valid;
      tick();
      if (ov) break;
    end
    idle_in();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_in();
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid got %b exp 0", mul_in_valid); end
    checks++; if ({hi_out, lo_out} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h exp 0", {hi_out, lo_out}); end
    checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL reset_wd got %b exp 0", wd_err); end
    tick();
  endtask

  task automatic test_multu_max();
    int n;
    lat = 3;
    set_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    checks++; if (n != 4) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 4", n); end
    @(negedge clk);
    checks++; if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL multu_acc_in_valid got %b exp 0", mul_in_valid); end
    checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_acc_hilo got %h exp FFFFFFFE00000001", {hi_out, lo_out}); end
    tick();
    @(negedge clk);
    checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_reg_hilo got %h exp FFFFFFFE00000001", {hi_out, lo_out}); end
    tick();
  endtask

  task automatic test_accumulate();
    int n;
    lat = 2;
    set_op(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_done(n);
    @(negedge clk);
    checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL mult_neg got %h exp FFFFFFFFFFFFFFFA", {hi_out, lo_out}); end
    tick();
    set_op(3'd2, 32'd2, 32'd3);
    wait_done(n);
    @(negedge clk);
    checks++; if ({hi_out, lo_out} !== 64'd0) begin errors++; $display("FAIL madd_wrap got %h exp 0", {hi_out, lo_out}); end
    tick();
    set_op(3'd5, 32'd1, 32'd1);
    wait_done(n);
    tick();
    @(negedge clk);
    checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL msubu_wrap got %h exp FFFFFFFFFFFFFFFF", {hi_out, lo_out}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    lat = 2;
    set_op(3'd0, 32'd5, 32'd7);
    wait_done(n);
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_first_busy got %0d exp 3", n); end
    set_op(3'd0, 32'd5, 32'd7);
    @(negedge clk);
    checks++; if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_in_valid got %b exp 0", mul_in_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_acc_busy got %b exp 0", busy); end
    checks++; if (lo_out !== 32'd35) begin errors++; $display("FAIL b2b_first_lo got %h exp 23", lo_out); end
    tick();
    wait_done(n);
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_second_busy got %0d exp 2", n); end
    @(negedge clk);
    checks++; if ({hi_out, lo_out} !== 64'd35) begin errors++; $display("FAIL b2b_second_hilo got %h exp 23", {hi_out, lo_out}); end
    tick();
  endtask

  task automatic test_flush();
    int n;
    lat = 3;
    set_op(3'd6, 32'h11, 32'd0);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
    tick();
    set_op(3'd7, 32'h22, 32'd0);
    tick();
    set_op(3'd0, 32'd4, 32'd4);
    tick(); tick();
    flush = 1'b1;
    tick();
    idle_in();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mul_in_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_idle got busy %b in_valid %b exp 0 0", busy, mul_in_valid); end
    checks++; if ({hi_out, lo_out} !== {32'h11, 32'h22}) begin errors++; $display("FAIL flush_wait_hilo got %h exp 0000001100000022", {hi_out, lo_out}); end
    tick();
    set_op(3'd0, 32'd4, 32'd4);
    wait_done(n);
    flush = 1'b1;
    tick();
    idle_in();
    @(negedge clk);
    checks++; if ({hi_out, lo_out} !== 64'd16) begin errors++; $display("FAIL flush_acc_hilo got %h exp 10", {hi_out, lo_out}); end
    tick();
  endtask

  task automatic test_mt_in_acc();
    int n;
    lat = 1;
    set_op(3'd1, 32'd2, 32'd3);
    wait_done(n);
    checks++; if (n != 2) begin errors++; $display("FAIL mt_acc_busy got %0d exp 2", n); end
    set_op(3'd7, 32'hABCD, 32'd0);
    @(negedge clk);
    checks++; if ({hi_out, lo_out} !== 64'd6) begin errors++; $display("FAIL mt_acc_bypass got %h exp 6", {hi_out, lo_out}); end
    tick();
    idle_in();
    @(negedge clk);
    checks++; if ({hi_out, lo_out} !== 64'h0000ABCD) begin errors++; $display("FAIL mt_acc_override got %h exp ABCD", {hi_out, lo_out}); end
    tick();
  endtask

  task automatic test_watchdog();
    withhold = 1'b1;
    lat = 3;
    set_op(3'd0, 32'd3, 32'd3);
    tick();
    idle_in();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 15) begin
        checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL wd_early got %b exp 0", wd_err); end
      end
      if (k == 16) begin
        checks++; if (wd_err !== 1'b1) begin errors++; $display("FAIL wd_set got %b exp 1", wd_err); end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (wd_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wd_sticky got wd %b busy %b exp 1 1", wd_err, busy); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    withhold = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || wd_err !== 1'b0 || mul_in_valid !== 1'b0) begin errors++; $display("FAIL rst_wait got busy %b wd %b in_valid %b exp 0 0 0", busy, wd_err, mul_in_valid); end
    checks++; if ({hi_out, lo_out} !== 64'd0) begin errors++; $display("FAIL rst_wait_hilo got %h exp 0", {hi_out, lo_out}); end
    tick();
  endtask

  task automatic test_random();
    int n;
    logic [2:0] o;
    logic [31:0] a, b;
    m_hl = {hi_out, lo_out};
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(1, 4);
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFFF;
      set_op(o, a, b);
      m_hl = ref_next(o, a, b, m_hl);
      if (o <= 3'd5) begin
        wait_done(n);
        checks++; if (n != lat + 1) begin errors++; $display("FAIL rnd_busy op %0d got %0d exp %0d", o, n, lat + 1); end
        @(negedge clk);
        checks++; if ({hi_out, lo_out} !== m_hl) begin errors++; $display("FAIL rnd_acc op %0d got %h exp %h", o, {hi_out, lo_out}, m_hl); end
        tick();
      end else begin
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_mt_busy got %b exp 0", busy); end
        tick();
        idle_in();
        @(negedge clk);
        checks++; if ({hi_out, lo_out} !== m_hl) begin errors++; $display("FAIL rnd_mt op %0d got %h exp %h", o, {hi_out, lo_out}, m_hl); end
        tick();
      end
      if ($urandom_range(0, 2) == 0) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    #1;
    test_reset();
    test_multu_max();
    test_accumulate();
    test_back_to_back();
    test_flush();
    test_mt_in_acc();
    test_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_mul_ctrl.md
Name: hilo_mul_ctrl

Overview:
- Sequences the shared 32x32 multiplier for EX-stage HI/LO instructions: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MTHI and MTLO.
- Owns the architectural HI/LO registers and raises a pipeline stall while a product is pending.
- Holds multiplier operands stable until the product is valid, then accumulates into HI/LO.
- Sits between the EX stage and the multiplier; drives its in_valid/sign/srca/srcb and consumes its out_valid/hi/lo.

Parameters:
- WAIT_MAX, 15: maximum WAIT cycles before the watchdog error flag sets.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  EX-stage HI/LO instruction present
- op  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 MTHI, 7 MTLO
- srca  in  32  rs operand
- srcb  in  32  rt operand
- flush  in  1  pipeline flush
- busy  out  1  stall request to EX
- hi_out  out  32  HI value for MFHI, with bypass
- lo_out  out  32  LO value for MFLO, with bypass
- mul_in_valid  out  1  to multiplier in_valid
- mul_sign  out  1  to multiplier sign
- mul_srca  out  32  to multiplier srca
- mul_srcb  out  32  to multiplier srcb
- mul_out_valid  in  1  from multiplier out_valid
- mul_hi  in  32  from multiplier hi
- mul_lo  in  32  from multiplier lo
- wd_err  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE; hi, lo, operand regs, product reg, wait counter and wd_err all 0. Outputs: busy 0, mul_in_valid 0, hi_out 0, lo_out 0.
- start = op_valid & ~flush & (op <= 5).
- IDLE:
  - On start: latch srca, srcb, op; sign = (op is 0, 2 or 4); go to WAIT.
  - MTHI (op 6) with op_valid & ~flush: hi <= srca. MTLO (op 7): lo <= srca. Both complete the same cycle with no stall.
- WAIT:
  - mul_in_valid = 1; mul_sign/srca/srcb driven from the latched regs, held constant for the whole state.
  - On mul_out_valid: product reg <= {mul_hi, mul_lo}; go to ACC.
  - flush: go to IDLE, no HI/LO write.
  - The wait counter increments each WAIT cycle. When it reaches WAIT_MAX, wd_err sets (sticky until rst); the state machine keeps waiting.
- ACC:
  - mul_in_valid = 0. This forces the multiplier to restart even for identical back-to-back operands.
  - Write {hi, lo} <= P for MULT/MULTU, {hi, lo} + P for MADD*, {hi, lo} - P for MSUB*. Arithmetic is 64-bit modulo 2^64; sign affects only the product.
  - flush is ignored in ACC: the instruction has left EX.
  - A new start in ACC is accepted (latch operands, go to WAIT); otherwise go to IDLE.
  - MTHI/MTLO in ACC overrides only its own half of the ACC result, because the later instruction wins.
- busy = (IDLE & start) | WAIT. busy is 0 in ACC, so the stalled instruction advances exactly at the WAIT->ACC edge.
- hi_out/lo_out: the registered values, except in ACC, where they present the combinational ACC result. A dependent MFHI/MFLO in the following instruction therefore reads the fresh value.
- Latency: MULT issued cycle 0 -> busy high cycles 0..N, where cycle N is the first with mul_out_valid=1. HI/LO are visible on hi_out/lo_out in cycle N+1 and registered at the end of cycle N+1.
- rst in any state: return to IDLE immediately; pending op discarded.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF with 3-cycle multiplier latency -> busy high 4 cycles, then hi=0xFFFFFFFE, lo=0x00000001; mul_in_valid drops in ACC.
- MULT -2 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; then MADD 2 x 3 -> {hi,lo}=0x0000000000000000 (wrap); then MSUBU 1 x 1 -> hi=lo=0xFFFFFFFF.
- Back-to-back identical MULT 5 x 7 (second issued in ACC) -> mul_in_valid low exactly one cycle between them; lo=35 both times; busy correct for the second op.
- flush in second WAIT cycle of MULT 4 x 4 with hi/lo preloaded 0x11/0x22 via MTHI/MTLO -> state IDLE, hi=0x11, lo=0x22 unchanged; flush in ACC -> write still happens.
- MTLO 0xABCD issued in the ACC cycle of MULTU 2 x 3 -> hi=0, lo=0xABCD; hi_out/lo_out in ACC show 0/6 (bypass).
- Multiplier out_valid withheld 20 cycles -> wd_err sets after 15 WAIT cycles and stays set; rst mid-WAIT -> busy 0, wd_err 0, hi/lo 0 next cycle.
